// File: rtl/neuron_pkg.sv
// Shared types and helpers for the neuron datapath stages.
// neuron_mac clamps results only when NEURON_SAT_EN is defined.
package neuron_pkg;

    localparam int DEF_DATA_W    = 18;
    localparam int DEF_FRAC_BITS = 8;
    localparam int WIDE_W        = 64;

    typedef logic signed [DEF_DATA_W-1:0] data_t;

    typedef enum logic {
        ACCUM = 1'b0,
        OUT   = 1'b1
    } mac_state_e;

    typedef struct packed {
        logic signed [WIDE_W-1:0] val;
        logic                     ovf;
    } sat_t;

    // Clamp a wide signed value into a w-bit signed range.
    function automatic sat_t sat_to_data(
        input logic signed [WIDE_W-1:0] r,
        input int                       w
    );
        logic signed [WIDE_W-1:0] hi;
        logic signed [WIDE_W-1:0] lo;
        sat_t                     s;
        hi    = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo    = ~hi;
        s.val = r;
        s.ovf = 1'b0;
        if (r > hi) begin
            s.val = hi;
            s.ovf = 1'b1;
        end else if (r < lo) begin
            s.val = lo;
            s.ovf = 1'b1;
        end
        return s;
    endfunction

endpackage

// File: rtl/neuron_mac.sv
// Multiply-accumulate neuron core: N_INPUTS (x, w) pairs + bias -> pre-activation.
// Define NEURON_SAT_EN to clamp results and report out_ovf; otherwise wrap.
module neuron_mac
    import neuron_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int N_INPUTS  = 4,
    parameter int FRAC_BITS = DEF_FRAC_BITS
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_x,
    input  logic signed [DATA_W-1:0] in_w,
    input  logic signed [DATA_W-1:0] bias,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     out_ovf
);

    localparam int CNT_W  = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam int ACC_W  = 2 * DATA_W + $clog2(N_INPUTS) + 1;
    localparam int PROD_W = 2 * DATA_W;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_INPUTS - 1);

    mac_state_e state;
    mac_state_e state_nx;

    logic                     run;
    logic [CNT_W-1:0]         cnt;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_nx;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [PROD_W-1:0] prod;
    logic signed [DATA_W-1:0] bias_q;
    logic signed [DATA_W-1:0] bias_use;
    logic signed [ACC_W:0]    shifted;
    logic signed [ACC_W:0]    bias_ext;
    logic signed [ACC_W:0]    r;
    logic signed [DATA_W-1:0] res_data;
    logic                     res_ovf;
    logic                     unused_hi;
    logic                     first;
    logic                     last;
    logic                     fire_in;

    // run holds in_ready low until the first edge after reset release.
    assign in_ready  = run && (state == ACCUM);
    assign out_valid = (state == OUT);
    assign fire_in   = in_valid && in_ready;
    assign first     = (cnt == '0);
    assign last      = (cnt == LAST);

    assign prod = $signed({{DATA_W{in_x[DATA_W-1]}}, in_x})
                * $signed({{DATA_W{in_w[DATA_W-1]}}, in_w});

    assign prod_ext = $signed({{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod});
    assign acc_nx   = first ? prod_ext : acc + prod_ext;
    assign bias_use = first ? bias : bias_q;

    // Arithmetic shift floors toward minus infinity.
    assign shifted  = $signed({acc_nx[ACC_W-1], acc_nx}) >>> FRAC_BITS;
    assign bias_ext = $signed({{(ACC_W+1-DATA_W){bias_use[DATA_W-1]}}, bias_use});
    assign r        = shifted + bias_ext;

`ifdef NEURON_SAT_EN
    sat_t sat;

    assign sat       = sat_to_data($signed({{(WIDE_W-ACC_W-1){r[ACC_W]}}, r}), DATA_W);
    assign res_data  = sat.val[DATA_W-1:0];
    assign res_ovf   = sat.ovf;
    assign unused_hi = ^sat.val[WIDE_W-1:DATA_W];
`else
    assign res_data  = r[DATA_W-1:0];
    assign res_ovf   = 1'b0;
    assign unused_hi = ^r[ACC_W:DATA_W];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACCUM;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ACCUM: begin
                if (fire_in && last) begin
                    state_nx = OUT;
                end
            end
            OUT: begin
                if (out_ready) begin
                    state_nx = ACCUM;
                end
            end
            default: state_nx = ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run      <= 1'b0;
            cnt      <= '0;
            acc      <= '0;
            bias_q   <= '0;
            out_data <= '0;
            out_ovf  <= 1'b0;
        end else begin
            run <= 1'b1;
            if (fire_in) begin
                acc <= acc_nx;
                if (first) begin
                    bias_q <= bias;
                end
                if (last) begin
                    cnt      <= '0;
                    out_data <= res_data;
                    out_ovf  <= res_ovf;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_neuron_mac.sv
// Directed bench for neuron_mac with a per-neuron arithmetic reference model.
// Expectations follow NEURON_SAT_EN the same way the design does.
module tb_neuron_mac;

    localparam int DW = 18;

    typedef struct {
        longint d;
        bit     o;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] in_x;
    logic signed [DW-1:0] in_w;
    logic signed [DW-1:0] bias;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [DW-1:0] out_data;
    logic                 out_ovf;

    int   passed = 0;
    int   total  = 0;
    exp_t q[$];

    neuron_mac #(
        .DATA_W   (18),
        .N_INPUTS (4),
        .FRAC_BITS(8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_x     (in_x),
        .in_w     (in_w),
        .bias     (bias),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_ovf  (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Exact sum, floor-divide by 2^8, add bias, then clamp or wrap to 18 bits.
    function automatic exp_t model(input longint xs[4], input longint ws[4],
                                   input longint b);
        exp_t   e;
        longint s;
        s = 0;
        for (int i = 0; i < 4; i++) s += xs[i] * ws[i];
        s = s >>> 8;
        s = s + b;
        e.o = 1'b0;
`ifdef NEURON_SAT_EN
        if (s > 131071) begin
            e.d = 131071;
            e.o = 1'b1;
        end else if (s < -131072) begin
            e.d = -131072;
            e.o = 1'b1;
        end else begin
            e.d = s;
        end
`else
        e.d = s & 64'h3FFFF;
        if (e.d >= 131072) e.d = e.d - 262144;
`endif
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_out_valid", 1, 0);
            end else begin
                chk("out_data", longint'(out_data), q[0].d);
                chk("out_ovf", longint'(out_ovf), longint'(q[0].o));
                chk("in_ready_in_out", longint'(in_ready), 0);
                if (out_ready) void'(q.pop_front());
            end
        end
    end

    task automatic beat(input longint x, input longint w, input longint b);
        int waited;
        waited   = 0;
        in_valid = 1'b1;
        in_x     = DW'(x);
        in_w     = DW'(w);
        bias     = DW'(b);
        @(negedge clk);
        while (!in_ready && waited < 20) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) chk("in_ready_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic neuron(input string name, input longint xs[4], input longint ws[4],
                          input longint b, input bit gap,
                          input longint lit_d, input bit lit_o);
        exp_t e;
        e = model(xs, ws, b);
        chk({name, "_model_d"}, e.d, lit_d);
        chk({name, "_model_o"}, longint'(e.o), longint'(lit_o));
        q.push_back(e);
        for (int i = 0; i < 4; i++) begin
            beat(xs[i], ws[i], (i == 0) ? b : 777);
            if (gap && i < 3) begin
                @(posedge clk);
                #1;
            end
        end
        chk({name, "_latency"}, longint'(out_valid), 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain", q.size(), 0);
    endtask

    task automatic check_zero(input string name);
        chk({name, "_in_ready"}, longint'(in_ready), 0);
        chk({name, "_out_valid"}, longint'(out_valid), 0);
        chk({name, "_out_data"}, longint'(out_data), 0);
        chk({name, "_out_ovf"}, longint'(out_ovf), 0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("in_ready_after_release", longint'(in_ready), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_x      = '0;
        in_w      = '0;
        bias      = '0;
        out_ready = 1'b1;
        #1;
        check_zero("reset");
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("in_ready_first_cycle", longint'(in_ready), 1);

        neuron("basic", '{256, 512, -256, 0}, '{256, 256, 256, 256}, 0, 1'b0, 512, 1'b0);
        drain();
        neuron("floor", '{1, 0, 0, 0}, '{-1, 0, 0, 0}, 10, 1'b0, 9, 1'b0);
        drain();
`ifdef NEURON_SAT_EN
        neuron("pos_sat", '{131071, 131071, 131071, 131071},
               '{131071, 131071, 131071, 131071}, 0, 1'b0, 131071, 1'b1);
        drain();
        neuron("neg_sat", '{-131072, -131072, -131072, -131072},
               '{131071, 131071, 131071, 131071}, 0, 1'b0, -131072, 1'b1);
        drain();
`else
        neuron("pos_wrap", '{131071, 131071, 131071, 131071},
               '{131071, 131071, 131071, 131071}, 0, 1'b0, -4096, 1'b0);
        drain();
        neuron("neg_wrap", '{-131072, -131072, -131072, -131072},
               '{131071, 131071, 131071, 131071}, 0, 1'b0, 2048, 1'b0);
        drain();
`endif
        neuron("gapped", '{256, 512, -256, 0}, '{256, 256, 256, 256}, 0, 1'b1, 512, 1'b0);
        drain();

        out_ready = 1'b0;
        neuron("stall", '{100, 200, 300, 400}, '{256, 256, 256, 256}, -5, 1'b0, 995, 1'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("stall_in_ready", longint'(in_ready), 0);
            chk("stall_out_valid", longint'(out_valid), 1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("next_in_ready", longint'(in_ready), 1);
        chk("next_out_valid", longint'(out_valid), 0);
        neuron("back_to_back", '{-512, 0, 0, 0}, '{257, 0, 0, 0}, 3, 1'b0, -511, 1'b0);
        drain();

        beat(1000, 1000, 50);
        beat(2000, 1000, 50);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("mid_accum_reset");
        release_reset();
        neuron("after_reset", '{256, 512, -256, 0}, '{256, 256, 256, 256}, 0, 1'b0, 512, 1'b0);
        drain();

        out_ready = 1'b0;
        neuron("reset_in_out", '{100, 0, 0, 0}, '{512, 0, 0, 0}, 1, 1'b0, 201, 1'b0);
        #2;
        rst_n = 1'b0;
        q.delete();
        #1;
        check_zero("out_state_reset");
        release_reset();
        neuron("final", '{256, 512, -256, 0}, '{256, 256, 256, 256}, 0, 1'b0, 512, 1'b0);
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
